// File: rtl/tx_segment_replay_buffer_if.sv
// tx_segment_replay_buffer_if: serializer/VRAM-side bus of the segment replay buffer.
// TX_SEGBUF_STATS_EN adds the replay_count/miss_count statistics outputs.
interface tx_segment_replay_buffer_if #(parameter int CNT_W = 12);
  logic [7:0] txid;
  logic [7:0] redundancy;
  logic [15:0] segment_num;
  logic [15:0] segment_num_max;
  logic [CNT_W-1:0] byte_data_counter;
  logic [7:0] live_data;
  logic [23:0] live_startaddr;
  logic frame_start;
  logic [7:0] dout;
  logic dout_valid;
  logic [23:0] startaddr;
  logic replay_miss;
  logic oneframe_done;
`ifdef TX_SEGBUF_STATS_EN
  logic [15:0] replay_count;
  logic [15:0] miss_count;
  modport master(
    output txid, redundancy, segment_num, segment_num_max, byte_data_counter, live_data, live_startaddr, frame_start,
    input dout, dout_valid, startaddr, replay_miss, oneframe_done, replay_count, miss_count
  );
  modport slave(
    input txid, redundancy, segment_num, segment_num_max, byte_data_counter, live_data, live_startaddr, frame_start,
    output dout, dout_valid, startaddr, replay_miss, oneframe_done, replay_count, miss_count
  );
`else
  modport master(
    output txid, redundancy, segment_num, segment_num_max, byte_data_counter, live_data, live_startaddr, frame_start,
    input dout, dout_valid, startaddr, replay_miss, oneframe_done
  );
  modport slave(
    input txid, redundancy, segment_num, segment_num_max, byte_data_counter, live_data, live_startaddr, frame_start,
    output dout, dout_valid, startaddr, replay_miss, oneframe_done
  );
`endif
endinterface

// File: rtl/tx_segment_replay_buffer.sv
// tx_segment_replay_buffer: records each segment payload on its first copy and replays it byte-exact for redundant copies.
// Define TX_SEGBUF_STATS_EN to add saturating replay_count/miss_count outputs.
module tx_segment_replay_buffer #(
  parameter int SEG_DEPTH = 150,
  parameter int PAYLOAD_BYTES = 1437,
  parameter int START_OFFSET = 46,
  parameter int CNT_W = 12
) (
  input logic clk125MHz,
  input logic rst,
  tx_segment_replay_buffer_if.slave bus
);
  localparam int AW = $clog2(SEG_DEPTH * PAYLOAD_BYTES);
  localparam int SW = $clog2(SEG_DEPTH);
  localparam logic [CNT_W-1:0] OPEN = CNT_W'(START_OFFSET);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD_BYTES - 1);
  typedef enum logic [1:0] {IDLE, RECORD, REPLAY, SKIP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [AW-1:0] addr_q, addr_d, base, ram_addr;
  logic [SW-1:0] slot_q, slot_d, slot_in;
  logic [SEG_DEPTH-1:0] valid_q, valid_d;
  logic [23:0] startaddr_q, startaddr_d;
  logic fin_q, fin_d, miss_q, miss_d, done_q, done_d, v1_q, v1_d, sel_q, sel_d, dv_q;
  logic [7:0] lv_q, rd_q, dout_q;
  logic open, busy, hit, last, in_rng, rec_ok, rep_ok, wr;
  logic [7:0] mem [SEG_DEPTH*PAYLOAD_BYTES];
  logic [23:0] addr_ram [SEG_DEPTH];
  assign slot_in = bus.segment_num[SW-1:0];
  assign in_rng = bus.segment_num < 16'(SEG_DEPTH);
  assign busy = state_q != IDLE;
  assign open = !busy && bus.byte_data_counter == OPEN;
  assign hit = busy && bus.byte_data_counter == OPEN + off_q;
  assign last = hit && off_q == LAST;
  assign rec_ok = bus.txid == 8'd1 && in_rng;
  assign rep_ok = bus.txid != 8'd1 && in_rng && valid_q[slot_in];
  assign base = AW'(bus.segment_num * PAYLOAD_BYTES);
  // Byte 0 is handled in the opening IDLE cycle, so the window states cover offsets 1..PAYLOAD_BYTES-1.
  assign ram_addr = busy ? addr_q : base;
  always_comb begin
    state_d = state_q;
    off_d = off_q + CNT_W'(1);
    addr_d = addr_q + AW'(1);
    slot_d = slot_q;
    fin_d = fin_q;
    startaddr_d = startaddr_q;
    miss_d = miss_q;
    valid_d = bus.frame_start ? '0 : valid_q;
    done_d = last && fin_q;
    v1_d = 1'b0;
    sel_d = 1'b0;
    wr = 1'b0;
    if (open) begin
      slot_d = slot_in;
      fin_d = bus.segment_num == bus.segment_num_max - 16'd1 && bus.txid >= bus.redundancy;
      off_d = CNT_W'(1);
      addr_d = base + AW'(1);
      state_d = rec_ok ? RECORD : rep_ok ? REPLAY : SKIP;
      startaddr_d = rec_ok ? bus.live_startaddr : rep_ok ? addr_ram[slot_in] : startaddr_q;
      miss_d = miss_q | (!rec_ok && !rep_ok && bus.txid != 8'd1);
      v1_d = rec_ok || rep_ok;
      sel_d = rec_ok;
      wr = rec_ok;
    end else if (busy) begin
      state_d = (!hit || last) ? IDLE : state_q;
      v1_d = hit && state_q != SKIP;
      sel_d = state_q == RECORD;
      wr = hit && state_q == RECORD;
      // A completed record sets its slot even under frame_start; an aborted one invalidates it.
      if (state_q == RECORD && (!hit || last)) valid_d[slot_q] = hit;
    end
  end
  always_ff @(posedge clk125MHz or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      off_q <= '0;
      addr_q <= '0;
      slot_q <= '0;
      fin_q <= 1'b0;
      valid_q <= '0;
      startaddr_q <= '0;
      miss_q <= 1'b0;
      done_q <= 1'b0;
      v1_q <= 1'b0;
      sel_q <= 1'b0;
      dv_q <= 1'b0;
      lv_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      addr_q <= addr_d;
      slot_q <= slot_d;
      fin_q <= fin_d;
      valid_q <= valid_d;
      startaddr_q <= startaddr_d;
      miss_q <= miss_d;
      done_q <= done_d;
      v1_q <= v1_d;
      sel_q <= sel_d;
      dv_q <= v1_q;
      lv_q <= bus.live_data;
      dout_q <= sel_q ? lv_q : rd_q;
    end
  always_ff @(posedge clk125MHz) begin
    if (wr) mem[ram_addr] <= bus.live_data;
    rd_q <= mem[ram_addr];
    if (open && rec_ok) addr_ram[slot_in] <= bus.live_startaddr;
  end
  assign bus.dout = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.startaddr = startaddr_q;
  assign bus.replay_miss = miss_q;
  assign bus.oneframe_done = done_q;
`ifdef TX_SEGBUF_STATS_EN
  logic [15:0] rc_q, rc_d, mc_q, mc_d;
  always_comb begin
    rc_d = bus.frame_start ? '0 : rc_q + 16'(last && state_q == REPLAY && rc_q != 16'hFFFF);
    mc_d = bus.frame_start ? '0 : mc_q + 16'(open && !rec_ok && !rep_ok && bus.txid != 8'd1 && mc_q != 16'hFFFF);
  end
  always_ff @(posedge clk125MHz or posedge rst)
    if (rst) begin
      rc_q <= '0;
      mc_q <= '0;
    end else begin
      rc_q <= rc_d;
      mc_q <= mc_d;
    end
  assign bus.replay_count = rc_q;
  assign bus.miss_count = mc_q;
`endif
endmodule

// File: tb/tb_tx_segment_replay_buffer.sv
// tb_tx_segment_replay_buffer: randomized windows against a per-segment payload model with a byte scoreboard.
module tb_tx_segment_replay_buffer;
  localparam int SD = 10, PB = 40, SO = 46;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #4 clk = ~clk;
  tx_segment_replay_buffer_if #(.CNT_W(12)) bus();
  tx_segment_replay_buffer #(.SEG_DEPTH(SD), .PAYLOAD_BYTES(PB), .START_OFFSET(SO), .CNT_W(12)) dut (
    .clk125MHz(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_vec = 0, n_err = 0;
  int tot_valid = 0, tot_exp = 0, ofd_seen = 0, ofd_exp = 0;
  int red = 3, seg_max = 100;
  logic [7:0] exp_q[$];
  logic [7:0] m_data [SD][PB];
  logic [23:0] m_addr [SD];
  bit m_valid [SD];
  logic [23:0] m_sa;
  bit m_miss;
  int m_rc, m_mc;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < SD; i++) m_valid[i] = 0;
    m_sa = '0;
    m_miss = 0;
    m_rc = 0;
    m_mc = 0;
  endtask
  always @(negedge clk)
    if (!rst) begin
      if (bus.dout_valid) begin
        tot_valid++;
        if (exp_q.size() == 0) check("dout_extra", bus.dout_valid, 1'b0);
        else check("dout", bus.dout, exp_q.pop_front());
      end
      if (bus.oneframe_done) ofd_seen++;
    end
  task automatic window(input int tx, input int seg, input int abort_at, input int gap,
                        input bit fs_last, input bit ramp, input logic [23:0] lsa);
    logic [7:0] bytes [PB];
    int n, mode;
    bit in_rng, fin, aborted;
    n = (abort_at >= 0) ? abort_at : PB;
    aborted = n < PB;
    in_rng = seg < SD;
    fin = (seg == seg_max - 1) && (tx >= red);
    mode = (tx == 1 && in_rng) ? 1 : (tx != 1 && in_rng && m_valid[seg]) ? 2 : 0;
    for (int k = 0; k < PB; k++) bytes[k] = (mode == 2) ? m_data[seg][k] : ramp ? k[7:0] : 8'($urandom);
    if (mode != 0) begin
      for (int k = 0; k < n; k++) exp_q.push_back(bytes[k]);
      tot_exp += n;
    end
    if (mode == 1) begin
      m_sa = lsa;
      m_addr[seg] = lsa;
    end else if (mode == 2) m_sa = m_addr[seg];
    else if (tx != 1) begin
      m_miss = 1;
      if (m_mc < 16'hFFFF) m_mc++;
    end
    bus.txid = 8'(tx);
    bus.segment_num = 16'(seg);
    bus.live_startaddr = lsa;
    bus.redundancy = 8'(red);
    bus.segment_num_max = 16'(seg_max);
    for (int k = 0; k < PB; k++) begin
      if (k == n) begin
        bus.byte_data_counter = '0;
        tick();
        break;
      end
      bus.byte_data_counter = 12'(SO + k);
      bus.live_data = (mode == 1) ? bytes[k] : 8'($urandom);
      bus.frame_start = fs_last && k == PB - 1;
      tick();
      if (k == 0) begin
        check("startaddr", bus.startaddr, m_sa);
        check("replay_miss", bus.replay_miss, m_miss);
        bus.txid = 8'($urandom);
        bus.segment_num = 16'($urandom);
        bus.live_startaddr = 24'($urandom);
      end
    end
    bus.frame_start = 1'b0;
    bus.byte_data_counter = '0;
    if (aborted) begin
      if (mode == 1) m_valid[seg] = 0;
    end else begin
      if (mode == 2 && m_rc < 16'hFFFF) m_rc++;
      if (fs_last) begin
        for (int i = 0; i < SD; i++) m_valid[i] = 0;
        m_rc = 0;
        m_mc = 0;
      end
      if (mode == 1) begin
        m_valid[seg] = 1;
        for (int k = 0; k < PB; k++) m_data[seg][k] = bytes[k];
      end
      if (fin) ofd_exp++;
    end
    check("oneframe_done", bus.oneframe_done, !aborted && fin);
`ifdef TX_SEGBUF_STATS_EN
    check("replay_count", bus.replay_count, 16'(m_rc));
    check("miss_count", bus.miss_count, 16'(m_mc));
`endif
    for (int g = 0; g < gap; g++) begin
      tick();
      if (g == 0) check("oneframe_pulse", bus.oneframe_done, 1'b0);
    end
  endtask
  task automatic fs_pulse();
    bus.byte_data_counter = '0;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    for (int i = 0; i < SD; i++) m_valid[i] = 0;
    m_rc = 0;
    m_mc = 0;
  endtask
  task automatic drain();
    bus.byte_data_counter = '0;
    repeat (3) tick();
    check("drain_empty", exp_q.size(), 0);
    check("valid_count", tot_valid, tot_exp);
  endtask
  task automatic rst_mid(input int seg, input int kk);
    for (int j = 0; j < kk - 2; j++) exp_q.push_back(m_data[seg][j]);
    tot_exp += kk - 2;
    bus.txid = 8'd2;
    bus.segment_num = 16'(seg);
    for (int k = 0; k < kk; k++) begin
      bus.byte_data_counter = 12'(SO + k);
      tick();
    end
    rst = 1'b1;
    #1;
    check("rst_dout_valid", bus.dout_valid, 1'b0);
    check("rst_startaddr", bus.startaddr, 24'h0);
    check("rst_replay_miss", bus.replay_miss, 1'b0);
    model_reset();
    exp_q.delete();
    bus.byte_data_counter = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask
  initial begin
    model_reset();
    bus.txid = 8'd0;
    bus.redundancy = 8'd3;
    bus.segment_num = '0;
    bus.segment_num_max = 16'd100;
    bus.byte_data_counter = '0;
    bus.live_data = '0;
    bus.live_startaddr = '0;
    bus.frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", bus.dout, 8'h0);
    check("reset_dout_valid", bus.dout_valid, 1'b0);
    check("reset_startaddr", bus.startaddr, 24'h0);
    check("reset_replay_miss", bus.replay_miss, 1'b0);
    check("reset_oneframe_done", bus.oneframe_done, 1'b0);
    rst = 1'b0;
    tick();
    window(1, 0, -1, 2, 0, 1, 24'h000123);
    window(2, 0, -1, 0, 0, 0, 24'($urandom));
    window(3, 0, -1, 2, 0, 0, 24'($urandom));
    drain();
    for (int s = 0; s < SD; s++) window(1, s, -1, s % 2, 0, 0, 24'($urandom));
    for (int s = SD - 1; s >= 0; s--) window(2, s, -1, $urandom_range(2), 0, 0, 24'($urandom));
    drain();
    window(1, 4, -1, 1, 1, 0, 24'($urandom));
    window(2, 4, -1, 1, 0, 0, 24'($urandom));
    window(1, 12, -1, 1, 0, 0, 24'($urandom));
    window(2, 5, -1, 1, 0, 0, 24'($urandom));
    window(2, 12, -1, 1, 0, 0, 24'($urandom));
    window(1, 7, 25, 1, 0, 0, 24'($urandom));
    window(2, 7, -1, 1, 0, 0, 24'($urandom));
    seg_max = 4;
    red = 2;
    window(1, 3, -1, 2, 0, 0, 24'($urandom));
    window(2, 3, -1, 2, 0, 0, 24'($urandom));
    red = 1;
    window(1, 3, -1, 2, 0, 0, 24'($urandom));
    drain();
    rst_mid(3, 20);
    window(1, 2, -1, 1, 0, 0, 24'($urandom));
    window(2, 2, -1, 1, 0, 0, 24'($urandom));
    drain();
    for (int i = 0; i < 80; i++) begin
      red = $urandom_range(1, 3);
      seg_max = $urandom_range(1, 12);
      if ($urandom_range(9) == 0) fs_pulse();
      window($urandom_range(1, 4), $urandom_range(0, 11),
             ($urandom_range(9) == 0) ? int'($urandom_range(1, PB - 1)) : -1,
             $urandom_range(3), $urandom_range(15) == 0, 0, 24'($urandom));
    end
    drain();
    check("oneframe_count", ofd_seen, ofd_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
